alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
//============================================================================
// Module   : alu_issue
// Brief    : Two-stage RV32I integer-ALU issue pipeline. S1 holds decoded op
//            and operands for an external combinational ALU; S2 captures the
//            result and destination register. Optional build macro
//            ALU_ILLEGAL_TRAP_EN adds the out_illegal port.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] pc,
  output logic [3:0]  alu_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic        out_illegal
`endif
);

  localparam logic [3:0] c_alu_add   = 4'd0;
  localparam logic [3:0] c_alu_sub   = 4'd1;
  localparam logic [3:0] c_alu_sll   = 4'd2;
  localparam logic [3:0] c_alu_slt   = 4'd3;
  localparam logic [3:0] c_alu_sltu  = 4'd4;
  localparam logic [3:0] c_alu_xor   = 4'd5;
  localparam logic [3:0] c_alu_srl   = 4'd6;
  localparam logic [3:0] c_alu_sra   = 4'd7;
  localparam logic [3:0] c_alu_or    = 4'd8;
  localparam logic [3:0] c_alu_and   = 4'd9;
  localparam logic [3:0] c_alu_b_out = 4'd11;

  localparam logic [6:0] c_op_reg   = 7'b0110011;
  localparam logic [6:0] c_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;
  localparam logic [6:0] c_f7_zero  = 7'b0000000;
  localparam logic [6:0] c_f7_alt   = 7'b0100000;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic        w_is_reg;
  logic        w_shift;
  logic        w_unused_rs_idx;

  logic [3:0]  w_sel;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_legal;

  logic        w_accept;
  logic        w_load;
  logic        w_s1_adv;
  logic        w_s1_zero;

  logic        r_s1_valid;
  logic [3:0]  r_s1_sel;
  logic [31:0] r_s1_a;
  logic [31:0] r_s1_b;
  logic [4:0]  r_s1_rd;

  logic        r_s2_valid;
  logic [4:0]  r_s2_rd;
  logic [31:0] r_s2_data;

  assign w_opcode        = instr[6:0];
  assign w_funct3        = instr[14:12];
  assign w_funct7        = instr[31:25];
  assign w_imm_i         = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_u         = {instr[31:12], 12'b0};
  assign w_is_reg        = (w_opcode == c_op_reg);
  assign w_shift         = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign w_unused_rs_idx = ^instr[19:15];

  // Decode; register and immediate forms share the funct3 table.
  always_comb begin
    w_sel   = c_alu_add;
    w_a     = '0;
    w_b     = '0;
    w_legal = 1'b0;
    case (w_opcode)
      c_op_reg, c_op_imm: begin
        w_a = rs1_data;
        case (w_funct3)
          3'b000:  w_sel = (w_is_reg && w_funct7[5]) ? c_alu_sub : c_alu_add;
          3'b001:  w_sel = c_alu_sll;
          3'b010:  w_sel = c_alu_slt;
          3'b011:  w_sel = c_alu_sltu;
          3'b100:  w_sel = c_alu_xor;
          3'b101:  w_sel = w_funct7[5] ? c_alu_sra : c_alu_srl;
          3'b110:  w_sel = c_alu_or;
          default: w_sel = c_alu_and;
        endcase
        if (w_is_reg) begin
          w_b     = w_shift ? {27'b0, rs2_data[4:0]} : rs2_data;
          w_legal = (w_funct7 == c_f7_zero) ||
                    ((w_funct7 == c_f7_alt) &&
                     ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
        end else begin
          w_b     = w_shift ? {27'b0, instr[24:20]} : w_imm_i;
          w_legal = !w_shift || (w_funct7 == c_f7_zero) ||
                    ((w_funct7 == c_f7_alt) && (w_funct3 == 3'b101));
        end
      end
      c_op_lui: begin
        w_sel   = c_alu_b_out;
        w_b     = w_imm_u;
        w_legal = 1'b1;
      end
      c_op_auipc: begin
        w_sel   = c_alu_add;
        w_a     = pc;
        w_b     = w_imm_u;
        w_legal = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 throughout reset.
  assign in_ready = rst_n && (!r_s1_valid || !r_s2_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);

`ifdef ALU_ILLEGAL_TRAP_EN
  logic r_s1_illegal;
  logic r_s2_illegal;

  assign w_load      = w_accept;
  assign w_s1_zero   = (r_s1_rd == 5'd0) || r_s1_illegal;
  assign out_illegal = r_s2_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_illegal <= 1'b0;
      r_s2_illegal <= 1'b0;
    end else begin
      if (w_load) begin
        r_s1_illegal <= !w_legal;
      end
      if (w_s1_adv) begin
        r_s2_illegal <= r_s1_illegal;
      end
    end
  end
`else
  // Illegal beats are consumed here and never occupy S1.
  assign w_load    = w_accept && w_legal;
  assign w_s1_zero = (r_s1_rd == 5'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sel   <= c_alu_add;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_rd    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_rd    <= '0;
      r_s2_data  <= '0;
    end else begin
      if (w_load) begin
        r_s1_valid <= 1'b1;
        r_s1_sel   <= w_sel;
        r_s1_a     <= w_a;
        r_s1_b     <= w_b;
        r_s1_rd    <= instr[11:7];
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_rd    <= r_s1_rd;
        r_s2_data  <= w_s1_zero ? 32'd0 : alu_result;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign alu_sel   = r_s1_sel;
  assign alu_a     = r_s1_a;
  assign alu_b     = r_s1_b;
  assign out_valid = r_s2_valid;
  assign out_rd    = r_s2_rd;
  assign out_data  = r_s2_data;

endmodule

`default_nettype wire
